// File: rtl/cpu_pkg.sv
// Shared types for the SM83 register-to-register sequencer: states, ALU ops, register/flag indices.
// Defining REG_SEQ_INCDEC_EN makes INC r / DEC r legal opcodes.
package cpu_pkg;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StExec = 2'd1;
  localparam state_t StWb   = 2'd2;
  localparam state_t StErr  = 2'd3;

  // The first eight encodings match the ooo field of 10ooosss.
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluAdc  = 4'd1,
    AluSub  = 4'd2,
    AluSbc  = 4'd3,
    AluAnd  = 4'd4,
    AluXor  = 4'd5,
    AluOr   = 4'd6,
    AluCp   = 4'd7,
    AluInc  = 4'd8,
    AluDec  = 4'd9,
    AluPass = 4'd10
  } alu_op_t;

  localparam logic [2:0] REG_B  = 3'd0;
  localparam logic [2:0] REG_C  = 3'd1;
  localparam logic [2:0] REG_D  = 3'd2;
  localparam logic [2:0] REG_E  = 3'd3;
  localparam logic [2:0] REG_H  = 3'd4;
  localparam logic [2:0] REG_L  = 3'd5;
  localparam logic [2:0] REG_HL = 3'd6;
  localparam logic [2:0] REG_A  = 3'd7;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

  // (HL) needs a memory cycle, so any r field of 6 is rejected; this also covers HALT (0x76).
  function automatic logic op_legal(input logic [7:0] op);
    logic legal;
    case (op[7:6])
      2'b01:   legal = (op[5:3] != REG_HL) && (op[2:0] != REG_HL);
      2'b10:   legal = (op[2:0] != REG_HL);
`ifdef REG_SEQ_INCDEC_EN
      2'b00:   legal = (op[2:1] == 2'b10) && (op[5:3] != REG_HL);
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit SM83 ALU producing a result and {Z,N,H,C}.
// INC/DEC (used only when REG_SEQ_INCDEC_EN is defined) operate on b_i and pass c_i through.
module alu8
  import cpu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  input  alu_op_t    op_i,
  output logic [7:0] res_o,
  output logic [3:0] flags_o
);

  logic [8:0] wide;
  logic [4:0] half;
  logic       cin;
  logic       n_flag;
  logic       h_flag;
  logic       c_flag;

  always_comb begin
    cin    = c_i && ((op_i == AluAdc) || (op_i == AluSbc));
    wide   = '0;
    half   = '0;
    res_o  = b_i;
    n_flag = 1'b0;
    h_flag = 1'b0;
    c_flag = c_i;
    case (op_i)
      AluAdd, AluAdc: begin
        wide   = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin};
        half   = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'd0, cin};
        res_o  = wide[7:0];
        h_flag = half[4];
        c_flag = wide[8];
      end
      // Bit 8 / bit 4 of the widened difference is the borrow.
      AluSub, AluSbc, AluCp: begin
        wide   = {1'b0, a_i} - {1'b0, b_i} - {8'd0, cin};
        half   = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'd0, cin};
        res_o  = wide[7:0];
        n_flag = 1'b1;
        h_flag = half[4];
        c_flag = wide[8];
      end
      AluAnd: begin
        res_o  = a_i & b_i;
        h_flag = 1'b1;
        c_flag = 1'b0;
      end
      AluXor: begin
        res_o  = a_i ^ b_i;
        c_flag = 1'b0;
      end
      AluOr: begin
        res_o  = a_i | b_i;
        c_flag = 1'b0;
      end
      AluInc: begin
        res_o  = b_i + 8'd1;
        h_flag = (b_i[3:0] == 4'hF);
      end
      AluDec: begin
        res_o  = b_i - 8'd1;
        n_flag = 1'b1;
        h_flag = (b_i[3:0] == 4'h0);
      end
      default: ;
    endcase
    flags_o         = '0;
    flags_o[FLAG_Z] = (res_o == 8'd0);
    flags_o[FLAG_N] = n_flag;
    flags_o[FLAG_H] = h_flag;
    flags_o[FLAG_C] = c_flag;
  end

endmodule

// File: rtl/reg_seq.sv
// SM83 register-to-register micro-sequencer: IDLE -> EXEC -> WB (legal) or IDLE -> ERR (illegal).
// Defining REG_SEQ_INCDEC_EN adds INC r / DEC r; otherwise they take the ERR path.
module reg_seq
  import cpu_pkg::*;
#(
  parameter logic [2:0] ACC_IDX   = 3'd7,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_op_valid,
  output logic       o_op_ready,
  input  logic [7:0] i_opcode,
  output logic [2:0] o_reg_a_sel,
  output logic [2:0] o_reg_b_sel,
  input  logic [7:0] i_reg_a,
  input  logic [7:0] i_reg_b,
  output logic [2:0] o_reg_wr_sel,
  output logic       o_reg_wr_en,
  output logic [7:0] o_reg_wr_data,
  output logic [3:0] o_flags,
  output logic       o_done,
  output logic       o_illegal
);

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] res_q, res_d;
  logic [3:0] fnew_q, fnew_d;
  logic [3:0] flags_q, flags_d;

  logic       is_ld, is_alu, is_incdec, is_cp, busy;
  logic [2:0] a_sel, b_sel, wr_sel;
  alu_op_t    alu_op;
  logic [7:0] alu_res;
  logic [3:0] alu_flags;

  always_comb begin
    is_ld     = (op_q[7:6] == 2'b01);
    is_alu    = (op_q[7:6] == 2'b10);
    is_incdec = (op_q[7:6] == 2'b00);
    is_cp     = is_alu && (op_q[5:3] == 3'd7);
    if (is_ld) begin
      alu_op = AluPass;
    end else if (is_alu) begin
      alu_op = alu_op_t'({1'b0, op_q[5:3]});
    end else if (op_q[0]) begin
      alu_op = AluDec;
    end else begin
      alu_op = AluInc;
    end
    a_sel  = is_alu ? ACC_IDX : REG_B;
    b_sel  = is_incdec ? op_q[5:3] : op_q[2:0];
    wr_sel = is_alu ? ACC_IDX : op_q[5:3];
  end

  alu8 u_alu (
    .a_i     (i_reg_a),
    .b_i     (i_reg_b),
    .c_i     (flags_q[FLAG_C]),
    .op_i    (alu_op),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    fnew_d  = fnew_q;
    flags_d = flags_q;
    case (state_q)
      StIdle: begin
        if (i_op_valid) begin
          op_d    = i_opcode;
          state_d = op_legal(i_opcode) ? StExec : StErr;
        end
      end
      StExec: begin
        res_d   = alu_res;
        fnew_d  = alu_flags;
        state_d = StWb;
      end
      StWb: begin
        if (!is_ld) begin
          flags_d = fnew_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      res_q   <= '0;
      fnew_q  <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      fnew_q  <= fnew_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    busy          = (state_q == StExec) || (state_q == StWb);
    o_op_ready    = (state_q == StIdle);
    o_done        = (state_q == StWb);
    o_illegal     = (state_q == StErr);
    o_reg_a_sel   = busy ? a_sel : 3'd0;
    o_reg_b_sel   = busy ? b_sel : 3'd0;
    o_reg_wr_en   = (state_q == StWb) && !is_cp;
    o_reg_wr_sel  = (state_q == StWb) ? wr_sel : 3'd0;
    o_reg_wr_data = (state_q == StWb) ? res_q : 8'd0;
    o_flags       = flags_q;
  end

endmodule
